montgomery_exp_ctrl: RTL and testbench
======================================

// Module: montgomery_exp_ctrl
// PURPOSE
//   Modular-exponentiation sequencer directly upstream of the 1024-bit Montgomery multiplier.
//   Computes result = X^E mod M using left-to-right square-and-multiply over all E_WIDTH bits.
//   All operands are in the Montgomery domain. A final multiply by 1 converts the result back to
//   the normal domain. Drives the multiplier's start/in_a/in_b/in_m and consumes its result/done.
// PARAMETERS
//   N        1024  operand / modulus width in bits (matches the multiplier)
//   E_WIDTH  1024  exponent width in bits; all bits are scanned (fixed op count, no leading-zero skip)
// PORTS
//   clk         in   1        single clock, all logic rising-edge
//   reset       in   1        asynchronous, active-high reset
//   start       in   1        1-cycle request; inputs sampled on the same edge
//   in_x        in   N        base in Montgomery form: X*R mod M, with R = 2^N
//   in_r        in   N        R mod M (Montgomery one); initial accumulator
//   in_e        in   E_WIDTH  exponent
//   in_m        in   N        odd modulus, M < 2^(N-1)
//   result      out  N        X^E mod M, normal domain; held until the next start
//   done        out  1        1-cycle pulse; result valid in the same cycle
//   busy        out  1        high from the cycle after start until done
//   mul_start   out  1        1-cycle pulse to the multiplier
//   mul_a       out  N        multiplier operand A (driven from the ACC register)
//   mul_b       out  N        multiplier operand B
//   mul_m       out  N        multiplier modulus (driven from the M register)
//   mul_result  in   N        multiplier result; valid when mul_done=1
//   mul_done    in   1        1-cycle pulse from the multiplier
// BEHAVIOUR
//   Reset values
//     state = IDLE; all outputs = 0.
//     Registers ACC, XR, MR, ER and bit counter = 0.
//   Capture
//     In IDLE, start=1 loads ACC<=in_r, XR<=in_x, MR<=in_m, ER<=in_e, cnt<=E_WIDTH-1.
//     start is ignored in every other state.
//   FSM states: IDLE -> SQ_GO -> SQ_WT -> [MU_GO -> MU_WT] -> NXT -> ... -> FN_GO -> FN_WT -> DONE -> IDLE
//     SQ_GO: mul_start=1, mul_a=ACC, mul_b=ACC.
//            Next state SQ_WT; wait there for mul_done, then ACC<=mul_result.
//     After SQ_WT: go to MU_GO if ER[cnt]=1, else go to NXT.
//     MU_GO: mul_start=1, mul_a=ACC, mul_b=XR.
//            Next state MU_WT; on mul_done, ACC<=mul_result.
//     NXT: if cnt==0 go to FN_GO; else cnt<=cnt-1 and go to SQ_GO.
//     FN_GO: mul_start=1, mul_a=ACC, mul_b=1 (zero-extended).
//            FN_WT: on mul_done, result<=mul_result.
//     DONE: done=1 for exactly one cycle; then IDLE.
//   Multiplier handshake
//     mul_a, mul_b and mul_m are registered. They are stable from the mul_start cycle through the
//     mul_done cycle, because the multiplier reads in_b and in_m on every iteration.
//     mul_start is never asserted while a multiply is outstanding.
//     A new mul_start follows mul_done by at least 1 cycle, since the multiplier needs one IDLE
//     cycle before accepting a new start.
//   Latency and op count
//     Multiplies per exponentiation = E_WIDTH squares + popcount(E) + 1 final.
//     Latency = sum of multiplier latencies + 2 cycles controller overhead per multiply + 2 cycles.
//   Data and arithmetic
//     No arithmetic in this block; it only routes and stores N-bit values.
//     mul_result is assumed < M, because the multiplier performs the final C-M step.
//     mul_done in IDLE or in a *_GO state is ignored (no ACC or result update).
//   Boundary cases
//     E=0: E_WIDTH squares of R stay at R; the final multiply gives result=1.
//     E=1: result = X mod M.
//     mul_done arriving in the same cycle as a start attempt while busy: the start is ignored and
//     the done is processed normally.
//   Reset mid-operation
//     Returns immediately to IDLE; mul_start=0, done=0, busy=0.
//     The integrator must reset the multiplier in the same cycle.
//   busy = (state != IDLE) && (state != DONE).
// TESTING
//   Bench multiplier: behavioural model with latency randomised 3..600 cycles, checking that
//   operands stay stable from mul_start to mul_done.
//   T1  E=0, M=random odd 1023-bit -> result==1; exactly E_WIDTH+1 mul_start pulses;
//       done high for 1 cycle.
//   T2  E=1, X=0x1234 -> result==0x1234; E_WIDTH+2 mul_start pulses.
//   T3  E=65537, random X and M (1023-bit) -> result==X^65537 mod M (golden model);
//       E_WIDTH+3 mul_start pulses.
//   T4  E=all-ones (E_WIDTH bits) -> result matches golden model; 2*E_WIDTH+1 pulses;
//       no mul_start within 1 cycle of any mul_done.
//   T5  start pulsed again while busy (mid SQ_WT) -> ignored; result equals the first job's
//       golden value.
//   T6  reset asserted in MU_WT -> next cycle busy=0, done=0, mul_start=0;
//       then a fresh start with E=3, X=5, M=7 (N=1024, zero-extended) -> result==6.

Source files
------------

// File: rtl/montgomery_exp_ctrl.sv
// Modular-exponentiation sequencer: left-to-right square-and-multiply over every exponent bit,
// issuing operations to an external Montgomery multiplier and finishing with a multiply by one.
module montgomery_exp_ctrl #(
  parameter int N       = 1024,
  parameter int E_WIDTH = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N-1:0]       in_x,
  input  logic [N-1:0]       in_r,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [N-1:0]       in_m,
  output logic [N-1:0]       result,
  output logic               done,
  output logic               busy,
  output logic               mul_start,
  output logic [N-1:0]       mul_a,
  output logic [N-1:0]       mul_b,
  output logic [N-1:0]       mul_m,
  input  logic [N-1:0]       mul_result,
  input  logic               mul_done
);

  localparam int            CW      = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(E_WIDTH - 1);
  localparam logic [N-1:0]  ONE_N   = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    SQ_GO = 4'd1,
    SQ_WT = 4'd2,
    MU_GO = 4'd3,
    MU_WT = 4'd4,
    NXT   = 4'd5,
    FN_GO = 4'd6,
    FN_WT = 4'd7,
    DONE  = 4'd8
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [N-1:0]         acc_r;
  logic [N-1:0]         xr_r;
  logic [N-1:0]         mr_r;
  logic [E_WIDTH-1:0]   er_r;
  logic [CW-1:0]        cnt_r;
  logic [N-1:0]         result_r;
  logic [N-1:0]         mul_b_r;
  logic                 mul_start_r;
  logic                 done_r;
  logic                 busy_r;
  logic                 capture_s;
  logic                 acc_load_s;
  logic                 bit_s;

  assign capture_s  = (state_r == IDLE) && start;
  assign acc_load_s = mul_done && ((state_r == SQ_WT) || (state_r == MU_WT));
  assign bit_s      = er_r[cnt_r];

  assign result    = result_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign mul_start = mul_start_r;
  assign mul_a     = acc_r;
  assign mul_b     = mul_b_r;
  assign mul_m     = mr_r;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; mul_done only matters in the wait states
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = SQ_GO;
        else       state_s = IDLE;
      end
      SQ_GO: state_s = SQ_WT;
      SQ_WT: begin
        if (mul_done) begin
          if (bit_s) state_s = MU_GO;
          else       state_s = NXT;
        end else begin
          state_s = SQ_WT;
        end
      end
      MU_GO: state_s = MU_WT;
      MU_WT: begin
        if (mul_done) state_s = NXT;
        else          state_s = MU_WT;
      end
      NXT: begin
        if (cnt_r == {CW{1'b0}}) state_s = FN_GO;
        else                     state_s = SQ_GO;
      end
      FN_GO: state_s = FN_WT;
      FN_WT: begin
        if (mul_done) state_s = DONE;
        else          state_s = FN_WT;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand storage: captured on an accepted start, ACC follows multiplier results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r <= {N{1'b0}};
      xr_r  <= {N{1'b0}};
      mr_r  <= {N{1'b0}};
      er_r  <= {E_WIDTH{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else begin
      if (capture_s) begin
        acc_r <= in_r;
        xr_r  <= in_x;
        mr_r  <= in_m;
        er_r  <= in_e;
        cnt_r <= CNT_TOP;
      end else if (acc_load_s) begin
        acc_r <= mul_result;
      end else if ((state_r == NXT) && (cnt_r != {CW{1'b0}})) begin
        cnt_r <= cnt_r - CW'(1);
      end
    end
  end

  // Final result, held until overwritten by the next completed job
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_r <= {N{1'b0}};
    end else if ((state_r == FN_WT) && mul_done) begin
      result_r <= mul_result;
    end
  end

  // Multiplier request: operand B is set up in the *_GO cycle and the start pulse lands the
  // cycle after, which also leaves one idle cycle between a mul_done and the next start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_start_r <= 1'b0;
      mul_b_r     <= {N{1'b0}};
    end else begin
      mul_start_r <= 1'b0;
      case (state_r)
        SQ_GO: begin
          mul_start_r <= 1'b1;
          mul_b_r     <= acc_r;
        end
        MU_GO: begin
          mul_start_r <= 1'b1;
          mul_b_r     <= xr_r;
        end
        FN_GO: begin
          mul_start_r <= 1'b1;
          mul_b_r     <= ONE_N;
        end
        default: begin
          mul_b_r <= mul_b_r;
        end
      endcase
    end
  end

  // Status flags registered from the upcoming state so they align with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= (state_s == DONE);
      busy_r <= (state_s != IDLE) && (state_s != DONE);
    end
  end

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Self-checking bench: behavioural Montgomery multiplier with random latency plus a plain
// modular-exponentiation golden model.
module tb_montgomery_exp_ctrl;

  localparam int N      = 64;
  localparam int EW     = 20;
  localparam int BUDGET = 40000;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  in_x;
  logic [N-1:0]  in_r;
  logic [EW-1:0] in_e;
  logic [N-1:0]  in_m;
  logic [N-1:0]  result;
  logic          done;
  logic          busy;
  logic          mul_start;
  logic [N-1:0]  mul_a;
  logic [N-1:0]  mul_b;
  logic [N-1:0]  mul_m;
  logic [N-1:0]  mul_result;
  logic          mul_done;

  int vectors  = 0;
  int errors   = 0;
  int n_starts = 0;
  int cyc      = 0;
  int last_done = -100;
  int lat       = 0;
  bit m_busy    = 1'b0;
  logic [N-1:0] op_a, op_b, op_m;

  montgomery_exp_ctrl #(.N(N), .E_WIDTH(EW)) dut (
    .clk(clk), .reset(rst), .start(start),
    .in_x(in_x), .in_r(in_r), .in_e(in_e), .in_m(in_m),
    .result(result), .done(done), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // a*b*2^-N mod m by bit-serial reduction
  function automatic logic [N-1:0] mont(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic [N-1:0] m);
    logic [2*N+1:0] t;
    logic [2*N+1:0] mm;
    mm = {{(N+2){1'b0}}, m};
    t  = {{(N+2){1'b0}}, a} * {{(N+2){1'b0}}, b};
    for (int i = 0; i < N; i++) begin
      if (t[0]) t = t + mm;
      t = t >> 1;
    end
    if (t >= mm) t = t - mm;
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] to_mont(input logic [N-1:0] x, input logic [N-1:0] m);
    logic [2*N-1:0] t;
    t = {x, {N{1'b0}}};
    t = t % {{N{1'b0}}, m};
    return t[N-1:0];
  endfunction

  // right-to-left binary exponentiation in ordinary arithmetic
  function automatic logic [N-1:0] modexp(input logic [N-1:0] x, input logic [EW-1:0] e,
                                          input logic [N-1:0] m);
    logic [2*N-1:0] r, b, mm;
    mm = {{N{1'b0}}, m};
    r  = {{(2*N-1){1'b0}}, 1'b1};
    b  = {{N{1'b0}}, x} % mm;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) r = (r * b) % mm;
      b = (b * b) % mm;
    end
    return r[N-1:0];
  endfunction

  function automatic logic [N-1:0] rand_mod();
    logic [N-1:0] m;
    m = {$urandom, $urandom};
    m[N-1] = 1'b0;
    m[N-2] = 1'b1;
    m[0]   = 1'b1;
    return m;
  endfunction

  function automatic logic [N-1:0] rand_val(input logic [N-1:0] m);
    logic [N-1:0] v;
    v = {$urandom, $urandom};
    return v % m;
  endfunction

  // Multiplier model and per-cycle protocol checks
  initial begin
    mul_done   = 1'b0;
    mul_result = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mul_done = 1'b0;
      if (rst) begin
        m_busy = 1'b0;
      end else begin
        check("busy_done_overlap", N'(busy & done), '0);
        if (mul_start) begin
          n_starts++;
          check("start_while_outstanding", N'(m_busy), '0);
          check("start_gap_after_done", N'((cyc - last_done) >= 2), N'(1));
          op_a   = mul_a;
          op_b   = mul_b;
          op_m   = mul_m;
          m_busy = 1'b1;
          if ($urandom_range(15, 0) == 0) lat = $urandom_range(600, 41);
          else                            lat = $urandom_range(40, 3);
        end else if (m_busy) begin
          check("stable_a", mul_a, op_a);
          check("stable_b", mul_b, op_b);
          check("stable_m", mul_m, op_m);
          lat--;
          if (lat == 0) begin
            mul_done   = 1'b1;
            mul_result = mont(op_a, op_b, op_m);
            m_busy     = 1'b0;
            last_done  = cyc;
          end
        end
      end
    end
  end

  task automatic launch(input logic [N-1:0] x, input logic [EW-1:0] e, input logic [N-1:0] m);
    @(negedge clk);
    in_x     = to_mont(x % m, m);
    in_r     = to_mont({{(N-1){1'b0}}, 1'b1}, m);
    in_e     = e;
    in_m     = m;
    start    = 1'b1;
    n_starts = 0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", N'(busy), N'(1));
  endtask

  task automatic finish_job(input string nm, input logic [N-1:0] exp, input int exp_pulses);
    bit got;
    got = 1'b0;
    for (int i = 0; i < BUDGET && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) begin
      check({nm, "_done_timeout"}, '0, N'(1));
    end else begin
      check({nm, "_result"}, result, exp);
      check({nm, "_busy_at_done"}, N'(busy), '0);
      check({nm, "_mul_starts"}, N'(n_starts), N'(exp_pulses));
      @(negedge clk);
      check({nm, "_done_one_cycle"}, N'(done), '0);
      check({nm, "_result_held"}, result, exp);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]  m, x, g;
    logic [EW-1:0] e;
    bit            hit;
    rst = 1'b1; start = 1'b0;
    in_x = '0; in_r = '0; in_e = '0; in_m = '0;
    repeat (3) @(negedge clk);
    check("rst_result", result, '0);
    check("rst_done", N'(done), '0);
    check("rst_busy", N'(busy), '0);
    check("rst_mul_start", N'(mul_start), '0);
    check("rst_mul_a", mul_a, '0);
    check("rst_mul_b", mul_b, '0);
    check("rst_mul_m", mul_m, '0);
    rst = 1'b0;

    check("pin_modexp_5_3_7", modexp(64'd5, 20'd3, 64'd7), 64'd6);
    check("pin_modexp_2_10", modexp(64'd2, 20'd10, 64'd1000003), 64'd1024);
    check("pin_mont_3_6_7", mont(64'd3, 64'd6, 64'd7), 64'd2);
    check("pin_mont_3_1_7", mont(64'd3, 64'd1, 64'd7), 64'd5);
    check("pin_to_mont_5_7", to_mont(64'd5, 64'd7), 64'd3);

    // T1: E = 0
    m = rand_mod(); x = rand_val(m);
    launch(x, '0, m);
    finish_job("t1_e0", 64'd1, EW + 1);

    // T2: E = 1
    m = rand_mod();
    launch(64'h1234, 20'd1, m);
    finish_job("t2_e1", 64'h1234, EW + 2);

    // T3: E = 65537
    m = rand_mod(); x = rand_val(m);
    launch(x, 20'd65537, m);
    finish_job("t3_e65537", modexp(x, 20'd65537, m), EW + 3);

    // T4: E all ones
    m = rand_mod(); x = rand_val(m);
    launch(x, {EW{1'b1}}, m);
    finish_job("t4_eones", modexp(x, {EW{1'b1}}, m), 2 * EW + 1);

    // T5: start attempts while busy, once mid-wait and once together with mul_done
    m = rand_mod(); x = rand_val(m); e = EW'($urandom);
    g = modexp(x, e, m);
    launch(x, e, m);
    hit = 1'b0;
    for (int i = 0; i < BUDGET && !hit; i++) begin
      @(negedge clk); #1;
      hit = m_busy;
    end
    check("t5_reach_wait", N'(hit), N'(1));
    in_x = rand_val(m); in_m = rand_mod(); in_e = EW'($urandom); start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < BUDGET && !hit; i++) begin
      @(negedge clk); #1;
      hit = mul_done;
    end
    check("t5_reach_done", N'(hit), N'(1));
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    finish_job("t5_restart_ignored", g, EW + $countones(e) + 1);

    // T6: reset while a multiply-by-X is outstanding, then E=3, X=5, M=7
    m = rand_mod(); x = rand_val(m) | 64'd2; e = EW'($urandom); e[EW-1] = 1'b1;
    launch(x, e, m);
    hit = 1'b0;
    for (int i = 0; i < BUDGET && !hit; i++) begin
      @(negedge clk); #1;
      hit = m_busy && (mul_b == in_x) && (in_x != in_r);
    end
    check("t6_reach_mu_wt", N'(hit), N'(1));
    rst = 1'b1;
    @(negedge clk); #1;
    check("t6_rst_busy", N'(busy), '0);
    check("t6_rst_done", N'(done), '0);
    check("t6_rst_mul_start", N'(mul_start), '0);
    rst = 1'b0;
    launch(64'd5, 20'd3, 64'd7);
    finish_job("t6_after_reset", 64'd6, EW + 3);

    // Random jobs
    for (int j = 0; j < 3; j++) begin
      m = rand_mod(); x = rand_val(m); e = EW'($urandom);
      launch(x, e, m);
      finish_job($sformatf("rand%0d", j), modexp(x, e, m), EW + $countones(e) + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
